// File: rtl/ahb_dmem_slave_if.sv
// AHB-Lite slave-side bus bundle for the data-memory slave.
// The slave modport sees the master's address/data phase signals as inputs
// and returns HREADYOUT, HRESP and HRDATA.
interface ahb_dmem_slave_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
);
  logic                   slv_hsel_i;
  logic [1:0]             slv_htrans_i;
  logic [HADDR_WIDTH-1:0] slv_haddr_i;
  logic                   slv_hwrite_i;
  logic [2:0]             slv_hsize_i;
  logic [2:0]             slv_hburst_i;
  logic [3:0]             slv_hprot_i;
  logic                   slv_hmastlock_i;
  logic [HDATA_WIDTH-1:0] slv_hwdata_i;
  logic                   slv_hready_i;
  logic                   slv_hready_o;
  logic                   slv_hresp_o;
  logic [HDATA_WIDTH-1:0] slv_hrdata_o;

  modport slave (
    input  slv_hsel_i, slv_htrans_i, slv_haddr_i, slv_hwrite_i, slv_hsize_i,
           slv_hburst_i, slv_hprot_i, slv_hmastlock_i, slv_hwdata_i, slv_hready_i,
    output slv_hready_o, slv_hresp_o, slv_hrdata_o
  );

  modport master (
    output slv_hsel_i, slv_htrans_i, slv_haddr_i, slv_hwrite_i, slv_hsize_i,
           slv_hburst_i, slv_hprot_i, slv_hmastlock_i, slv_hwdata_i, slv_hready_i,
    input  slv_hready_o, slv_hresp_o, slv_hrdata_o
  );
endinterface

// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory slave: single transfers into a word-addressed array
// with byte/halfword/word lane writes, WAIT_STATES wait cycles per OKAY
// data phase, and the two-cycle ERROR response for illegal accesses.
module ahb_dmem_slave #(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     HDATA_WIDTH = 32,
  parameter int                     MEM_AW      = 10,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                     WAIT_STATES = 0
) (
  input logic             clk,
  input logic             rst,
  ahb_dmem_slave_if.slave slv
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             wcnt_q, wcnt_d;
  logic [MEM_AW-1:0]      idx_q;
  logic [3:0]             be_q;
  logic                   write_q;

  logic                   accept;
  logic                   take;
  logic                   complete;
  logic                   wr_commit;
  logic                   size_err;
  logic                   below_base;
  logic                   range_err;
  logic                   addr_err;
  logic [3:0]             be_a;
  logic [HADDR_WIDTH-1:0] offset;
  logic [HADDR_WIDTH-1:0] word_off;
  logic [MEM_AW-1:0]      idx_a;
  logic                   hready;
  logic                   hresp;
  logic [HDATA_WIDTH-1:0] rd_word;
  logic                   unused_bits;

  // Burst, protection and lock carry no meaning for this memory; the low
  // offset bits are consumed through the lane-select logic instead.
  assign unused_bits = ^{slv.slv_hburst_i, slv.slv_hprot_i, slv.slv_hmastlock_i, offset[1:0]};

  assign accept     = slv.slv_hsel_i & slv.slv_htrans_i[1] & slv.slv_hready_i;
  assign offset     = slv.slv_haddr_i - BASE_ADDR;
  assign word_off   = offset >> 2;
  assign below_base = slv.slv_haddr_i < BASE_ADDR;
  assign range_err  = (word_off >> MEM_AW) != '0;
  assign idx_a      = offset[MEM_AW+1:2];
  assign addr_err   = size_err | below_base | range_err;

  // Decode transfer size into little-endian byte lanes and flag misalignment.
  always_comb begin
    be_a     = 4'b0000;
    size_err = 1'b0;
    case (slv.slv_hsize_i)
      3'b000: be_a = 4'b0001 << slv.slv_haddr_i[1:0];
      3'b001: begin
        be_a     = slv.slv_haddr_i[1] ? 4'b1100 : 4'b0011;
        size_err = slv.slv_haddr_i[0];
      end
      3'b010: begin
        be_a     = 4'b1111;
        size_err = |slv.slv_haddr_i[1:0];
      end
      default: size_err = 1'b1;
    endcase
  end

  // Data-phase sequencing: wait countdown, completion, two-cycle error,
  // and pickup of a pipelined address phase in any cycle that drives hready=1.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    hready   = 1'b1;
    hresp    = 1'b0;
    take     = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        take = accept;
      end
      S_DATA: begin
        if (wcnt_q != 3'd0) begin
          hready = 1'b0;
          wcnt_d = wcnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          take     = accept;
          state_d  = S_IDLE;
        end
      end
      S_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        hresp   = 1'b1;
        take    = accept;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      if (addr_err) begin
        state_d = S_ERR1;
        wcnt_d  = 3'd0;
      end else begin
        state_d = S_DATA;
        wcnt_d  = 3'(WAIT_STATES);
      end
    end
  end

  // State, wait counter and captured address-phase attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      idx_q   <= '0;
      be_q    <= 4'b0000;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (take) begin
        idx_q   <= idx_a;
        be_q    <= be_a;
        write_q <= slv.slv_hwrite_i;
      end
    end
  end

  assign wr_commit = complete & write_q;

  // One byte-wide array per lane so each lane's write enable stays independent.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];

    // Commit this lane of the write data at the edge ending the completing cycle.
    always_ff @(posedge clk) begin
      if (wr_commit && be_q[gi]) begin
        mem_lane[idx_q] <= slv.slv_hwdata_i[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = mem_lane[idx_q];
  end

  assign slv.slv_hready_o = hready;
  assign slv.slv_hresp_o  = hresp;
  assign slv.slv_hrdata_o = (complete & ~write_q) ? rd_word : '0;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Bench for ahb_dmem_slave: two instances (0 and 3 wait states) are exercised
// one after the other. A transaction-level model turns every accepted
// transfer into the list of per-cycle (hready, hresp, hrdata) values it must
// produce; a single negedge process compares the DUT against that list.
module tb_ahb_dmem_slave;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          MAW  = 10;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    bit          lit;
    logic [31:0] lit_data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  ahb_dmem_slave_if bus0 ();
  ahb_dmem_slave_if bus1 ();

  assign bus0.slv_hready_i = bus0.slv_hready_o;
  assign bus1.slv_hready_i = bus1.slv_hready_o;

  ahb_dmem_slave #(.HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_AW(MAW),
                   .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst0), .slv(bus0));
  ahb_dmem_slave #(.HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_AW(MAW),
                   .BASE_ADDR(BASE), .WAIT_STATES(3)) dut1 (.clk(clk), .rst(rst1), .slv(bus1));

  exp_t        exp_q [2][$];
  logic [31:0] mm [2][1024];
  int          stall_cnt [2];
  int          stall_seen [2];
  int          n_vec = 0;
  int          n_mis = 0;

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic rdy_of(int k);
    return (k == 0) ? bus0.slv_hready_o : bus1.slv_hready_o;
  endfunction

  task automatic set_rst(int k, logic v);
    if (k == 0) rst0 = v; else rst1 = v;
  endtask

  task automatic set_addr(int k, logic sel, logic [1:0] tr, logic [31:0] a, logic w, logic [2:0] sz);
    if (k == 0) begin
      bus0.slv_hsel_i = sel; bus0.slv_htrans_i = tr; bus0.slv_haddr_i = a;
      bus0.slv_hwrite_i = w; bus0.slv_hsize_i = sz;
    end else begin
      bus1.slv_hsel_i = sel; bus1.slv_htrans_i = tr; bus1.slv_haddr_i = a;
      bus1.slv_hwrite_i = w; bus1.slv_hsize_i = sz;
    end
  endtask

  task automatic set_wdata(int k, logic [31:0] d);
    if (k == 0) bus0.slv_hwdata_i = d; else bus1.slv_hwdata_i = d;
  endtask

  task automatic push(int k, logic r, logic s, logic [31:0] d, bit lit, logic [31:0] ld);
    exp_t e;
    e.rdy = r; e.resp = s; e.data = d; e.lit = lit; e.lit_data = ld;
    exp_q[k].push_back(e);
  endtask

  // Transaction-level model: legality, latency and memory effect of one
  // accepted transfer, expressed as the cycles of its data phase.
  task automatic model_accept(int k, logic [31:0] a, logic w, logic [2:0] sz,
                              logic [31:0] wd, bit lit, logic [31:0] ld);
    logic [31:0] off;
    bit          err;
    int          idx;
    off = a - BASE;
    err = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
          (a < BASE) || ((off >> 2) >= (32'd1 << MAW));
    if (err) begin
      push(k, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
      push(k, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
    end else begin
      idx = int'(off[MAW+1:2]);
      repeat (ws_of(k)) push(k, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if (w) begin
        set_wdata(k, wd);
        for (int b = 0; b < 4; b++) begin
          if ((sz == 3'd0 && b == int'(a[1:0])) ||
              (sz == 3'd1 && (b / 2) == int'(a[1])) ||
              (sz == 3'd2))
            mm[k][idx][b*8 +: 8] = wd[b*8 +: 8];
        end
        push(k, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      end else begin
        push(k, 1'b1, 1'b0, mm[k][idx], lit, ld);
      end
    end
  endtask

  // Present one address phase, hold it until the bus is ready, then record
  // what its data phase must look like.
  task automatic issue(int k, logic sel, logic [1:0] tr, logic [31:0] a, logic w,
                       logic [2:0] sz, logic [31:0] wd, bit lit, logic [31:0] ld);
    logic r;
    int   guard;
    guard = 0;
    set_addr(k, sel, tr, a, w, sz);
    do begin
      @(negedge clk);
      r = rdy_of(k);
      @(posedge clk);
      #1;
      guard++;
    end while (!r && guard < 20);
    if (!r) stall_cnt[k]++;
    set_addr(k, 1'b0, 2'b00, a, 1'b0, 3'd0);
    if (r && sel && tr[1]) model_accept(k, a, w, sz, wd, lit, ld);
  endtask

  task automatic wr(int k, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
    issue(k, 1'b1, 2'b10, a, 1'b1, sz, wd, 1'b0, 32'h0);
  endtask

  task automatic rd(int k, logic [31:0] a, bit lit, logic [31:0] ld);
    issue(k, 1'b1, 2'b10, a, 1'b0, 3'd2, 32'h0, lit, ld);
  endtask

  task automatic idle(int k, int n);
    repeat (n) issue(k, 1'b0, 2'b00, BASE, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0);
  endtask

  // Reset lands in the second data cycle of a write (the only data cycle
  // when there are no wait states); the write must be lost.
  task automatic reset_mid_write(int k);
    logic [31:0] old;
    old = mm[k][4];
    wr(k, BASE + 32'd16, 3'd2, 32'h1234_5678);
    if (ws_of(k) > 0) begin
      @(posedge clk);
      #1;
    end
    set_rst(k, 1'b1);
    exp_q[k].delete();
    mm[k][4] = old;
    repeat (2) @(posedge clk);
    #1;
    set_rst(k, 1'b0);
  endtask

  task automatic run_suite(int k);
    int          r;
    logic [31:0] a;
    logic [2:0]  sz;
    repeat (3) @(posedge clk);
    #1;
    set_rst(k, 1'b0);
    for (int i = 0; i < 16; i++) wr(k, BASE + 32'(4 * i), 3'd2, $urandom);
    // word write then read back
    wr(k, BASE + 32'd8, 3'd2, 32'hDEAD_BEEF);
    rd(k, BASE + 32'd8, 1'b1, 32'hDEAD_BEEF);
    // byte and halfword lane merges
    wr(k, BASE, 3'd2, 32'h1122_3344);
    wr(k, BASE + 32'd1, 3'd0, 32'h0000_AA00);
    wr(k, BASE + 32'd2, 3'd1, 32'hBBCC_0000);
    rd(k, BASE, 1'b1, 32'hBBCC_AA44);
    // back-to-back reads
    rd(k, BASE + 32'd8, 1'b1, 32'hDEAD_BEEF);
    rd(k, BASE, 1'b1, 32'hBBCC_AA44);
    idle(k, 2);
    // illegal accesses, then confirm word 0 untouched
    wr(k, BASE + 32'd2, 3'd2, 32'hFFFF_FFFF);
    rd(k, BASE + 32'(4 * (1 << MAW)), 1'b0, 32'h0);
    issue(k, 1'b1, 2'b10, BASE, 1'b1, 3'b011, 32'h0BAD_0BAD, 1'b0, 32'h0);
    rd(k, BASE, 1'b1, 32'hBBCC_AA44);
    // non-transfers
    issue(k, 1'b1, 2'b00, BASE, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0);
    issue(k, 1'b1, 2'b01, BASE, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0);
    issue(k, 1'b0, 2'b10, BASE, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0);
    // reset mid write
    wr(k, BASE + 32'd16, 3'd2, 32'hCAFE_F00D);
    idle(k, 1);
    reset_mid_write(k);
    rd(k, BASE + 32'd16, 1'b1, 32'hCAFE_F00D);
    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        issue(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), BASE, 1'b0, 3'd2,
              32'h0, 1'b0, 32'h0);
      end else if (r < 12) begin
        issue(k, 1'b0, 2'($urandom_range(2, 3)), BASE, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0);
      end else if (r < 18) begin
        case ($urandom_range(0, 2))
          0:       a = BASE - 32'd4;
          1:       a = BASE + 32'(4 * (1 << MAW)) + 32'($urandom_range(0, 255) * 4);
          default: a = 32'($urandom_range(0, 255));
        endcase
        issue(k, 1'b1, 2'b10, a, 1'($urandom_range(0, 1)), 3'd2, $urandom, 1'b0, 32'h0);
      end else begin
        a  = BASE + 32'($urandom_range(0, 63));
        sz = (r < 22) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        issue(k, 1'b1, 2'($urandom_range(2, 3)), a, 1'($urandom_range(0, 1)), sz,
              $urandom, 1'b0, 32'h0);
      end
    end
    idle(k, ws_of(k) + 4);
  endtask

  // Single checker: one comparison per instance per cycle, plus literal pins.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t        e;
      logic        r, s, in_rst;
      logic [31:0] d;
      r      = (k == 0) ? bus0.slv_hready_o : bus1.slv_hready_o;
      s      = (k == 0) ? bus0.slv_hresp_o  : bus1.slv_hresp_o;
      d      = (k == 0) ? bus0.slv_hrdata_o : bus1.slv_hrdata_o;
      in_rst = (k == 0) ? rst0 : rst1;
      e.rdy = 1'b1; e.resp = 1'b0; e.data = 32'h0; e.lit = 1'b0; e.lit_data = 32'h0;
      if (!in_rst && exp_q[k].size() > 0) e = exp_q[k].pop_front();
      n_vec++;
      if (r !== e.rdy || s !== e.resp || d !== e.data) begin
        n_mis++;
        $display("FAIL cycle dut%0d t=%0t: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 k, $time, r, s, d, e.rdy, e.resp, e.data);
      end
      if (e.lit) begin
        n_vec++;
        if (d !== e.lit_data || e.data !== e.lit_data) begin
          n_mis++;
          $display("FAIL literal dut%0d t=%0t: got rdata=%h model=%h, want %h",
                   k, $time, d, e.data, e.lit_data);
        end
      end
      if (stall_cnt[k] != stall_seen[k]) begin
        stall_seen[k] = stall_cnt[k];
        n_vec++;
        n_mis++;
        $display("FAIL stall dut%0d t=%0t: got hready low for 20 cycles, want ready", k, $time);
      end
    end
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stall_cnt[k] = 0;
      stall_seen[k] = 0;
      set_addr(k, 1'b0, 2'b00, BASE, 1'b0, 3'd0);
      set_wdata(k, 32'h0);
    end
    bus0.slv_hburst_i = 3'd0; bus0.slv_hprot_i = 4'd0; bus0.slv_hmastlock_i = 1'b0;
    bus1.slv_hburst_i = 3'd0; bus1.slv_hprot_i = 4'd0; bus1.slv_hmastlock_i = 1'b0;
    run_suite(0);
    run_suite(1);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by t=%0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
